serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result bit count (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to add a and b; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, captured on start acceptance.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, captured on start acceptance.
REQ-007 SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port sum, output, WIDTH bits: registered result, a+b modulo 2^WIDTH.
REQ-010 SHALL have port carry, output, 1 bit: registered carry-out of the MSB.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1 at a clk edge, load a and b into shift registers, clear the carry flip-flop, clear the bit counter and enter RUN.
REQ-013 SHALL, in each RUN cycle, add the LSBs of both shift registers plus the carry flip-flop, shift the sum bit into the MSB of a sum shift register, shift both operand registers right, update the carry flip-flop and increment the counter.
REQ-014 SHALL leave RUN after exactly WIDTH RUN cycles, copying the sum shift register to sum and the final carry to carry, then enter DONE.
REQ-015 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE.
REQ-016 SHALL give a latency of WIDTH+1 clock edges from the edge that accepts start to the first cycle in which done=1.
REQ-017 SHALL hold sum and carry stable from DONE until the next result is written, including through the next RUN.
REQ-018 SHALL ignore start in RUN and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-019 SHALL accept start on the first IDLE cycle after DONE, so the back-to-back period is WIDTH+2 cycles.
REQ-020 SHALL produce wrap-around results: all-ones plus 1 gives sum=0, carry=1.
REQ-021 SHALL be structured so the counter width is clog2(WIDTH)+1 bits, making terminal count WIDTH representable without overflow.

Reset
REQ-022 SHALL, on rst=1 at a clk edge, force state IDLE, busy=0, done=0, sum=0, carry=0, counter=0, carry flip-flop=0 and clear all shift registers.
REQ-023 SHALL give rst priority over start and over any state, aborting an addition in progress with no done pulse.
REQ-024 SHALL accept start on the first edge after rst deasserts.

Structure
REQ-025 SHALL place the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) in a shared include file serial_adder_defs.vh, protected by an include guard.
REQ-026 SHALL instantiate one full_adder sub-module (ports a, b, cin, sum, cout), itself built structurally from two halfadder_struct instances and an OR gate, for the per-bit addition.
REQ-027 SHALL keep the FSM and the shift/counter registers in serial_adder, with no combinational path from any input to any output.

Verification
REQ-028 Reset, then start with a=8'h00, b=8'h00 -> done at edge 9 after start, with sum=8'h00 and carry=0.
REQ-029 Start with a=8'hA5, b=8'h5A -> sum=8'hFF, carry=0; busy=1 for exactly 10 cycles.
REQ-030 Start with a=8'hFF, b=8'h01 -> sum=8'h00, carry=1 (wrap-around).
REQ-031 Start with a=8'h0F, b=8'h01; at cycle 3 pulse start with a=8'hFF, b=8'hFF -> the second start is ignored; result is sum=8'h10, carry=0; exactly one done pulse.
REQ-032 Start, assert rst at RUN cycle 4 -> next cycle busy=0, sum=0, carry=0; no done pulse; a new start with a=8'h7F, b=8'h01 -> sum=8'h80, carry=0.
REQ-033 Hold start=1 continuously -> done pulses every 10 cycles; sum is unchanged between pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Common constants and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Default operand width.
  localparam int DEFAULT_WIDTH = 8;

  // The bit counter must reach WIDTH itself, so it needs one bit more than
  // clog2(WIDTH).
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_defs.vh
// Shared FSM state encodings for serial_adder.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH

localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_RUN  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;

`endif

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders and an OR gate.

module halfadder_struct (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  xor u_xor (sum, a, b);
  and u_and (carry, a, b);

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  halfadder_struct u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  halfadder_struct u_ha1 (
    .a     (s0),
    .b     (cin),
    .sum   (sum),
    .carry (c1)
  );

  or u_or (cout, c0, c1);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per clock, LSB first, WIDTH cycles per add.
// All outputs come straight from flops.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  `include "serial_adder_defs.vh"

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_ff;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  assign last_bit = (cnt == LAST_CNT);

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_ff),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state decode: start only matters in IDLE, DONE always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and status flags; busy spans the whole operation up to and
  // including the cycle in which done is shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE) || (state == ST_DONE);
      done  <= (state == ST_DONE);
    end
  end

  // Operand capture, serial shifting, counting and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= {WIDTH{1'b0}};
      b_sr     <= {WIDTH{1'b0}};
      sum_sr   <= {WIDTH{1'b0}};
      carry_ff <= 1'b0;
      cnt      <= {CW{1'b0}};
      sum      <= {WIDTH{1'b0}};
      carry    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            sum_sr   <= {WIDTH{1'b0}};
            carry_ff <= 1'b0;
            cnt      <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr   <= {fa_sum, sum_sr[WIDTH-1:1]};
          carry_ff <= fa_cout;
          cnt      <= cnt + CNT_ONE;
          // Publish on the final bit so sum/carry hold through the next RUN.
          if (last_bit) begin
            sum   <= {fa_sum, sum_sr[WIDTH-1:1]};
            carry <= fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8), random and directed adds
// compared against plain integer addition.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int total;
  int bad;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: ordinary (WIDTH+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete addition; optionally pulses a second start mid-run.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input bit pulse);
    logic [W:0] exp;
    int busy_cnt;
    int done_cnt;
    int done_edge;
    exp = ref_add(x, y);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    busy_cnt = 0;
    done_cnt = 0;
    done_edge = -1;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
      if (pulse && k == 3) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end
    check("done_latency", 32'(done_edge), 32'(W + 1));
    check("done_count", 32'(done_cnt), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(W + 2));
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("carry", 32'(carry), 32'(exp[W]));
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   exp;
    logic [W-1:0] held;
    int           last;
    int           pulses;
    int           done_seen;

    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    rst = 1'b0;

    // Directed cases: zero, no-carry pattern, wrap-around, ignored restart.
    do_add(8'h00, 8'h00, 1'b0);
    do_add(8'hA5, 8'h5A, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0);
    do_add(8'h0F, 8'h01, 1'b1);

    // Abort mid-run with reset: no done, outputs cleared.
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) done_seen++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_no_done", 32'(done_seen), 32'd0);
    do_add(8'h7F, 8'h01, 1'b0);

    // Random operands.
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      do_add(x, y, 1'b0);
    end

    // Start held high: pulses every WIDTH+2 cycles, result held between.
    x = W'($urandom);
    y = W'($urandom);
    exp = ref_add(x, y);
    start = 1'b1;
    a = x;
    b = y;
    last = -1;
    pulses = 0;
    held = 8'h00;
    for (int k = 0; k < 35; k++) begin
      tick();
      if (done) begin
        if (pulses > 0) check("hold_period", 32'(k - last), 32'(W + 2));
        check("hold_sum", 32'(sum), 32'(exp[W-1:0]));
        check("hold_carry", 32'(carry), 32'(exp[W]));
        held = sum;
        last = k;
        pulses++;
      end else if (pulses > 0) begin
        check("hold_stable", 32'(sum), 32'(held));
      end
    end
    start = 1'b0;
    check("hold_pulses", 32'(pulses), 32'd3);
    for (int k = 0; k < 15; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
